muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: one bit per cycle, 32-cycle iteration.
// Divide-by-zero and signed divide overflow resolve at acceptance when
// EARLY_OUT is set; otherwise they iterate and get overridden at the end.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating, one shift-add / restoring step per cycle
// DONE  | result valid, done pulse; start may be accepted here
module muldiv_unit #(
  parameter int unsigned EARLY_OUT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic        neg_q;
  logic        special_q;
  logic [31:0] special_val_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] opnd_q;

  logic        a_signed_in;
  logic        b_signed_in;
  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] a_mag_in;
  logic [31:0] b_mag_in;
  logic        neg_in;
  logic        div_zero_in;
  logic        ovf_in;
  logic        special_in;
  logic [31:0] special_val_in;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_fits;
  logic [31:0] hi_nxt;
  logic [31:0] lo_nxt;
  logic [63:0] prod_s;
  logic [31:0] mul_res;
  logic [31:0] div_raw;
  logic [31:0] div_res;
  logic [31:0] final_res;

  // Decode the incoming request: operand signedness, magnitudes, final sign
  // and the special-case divide results.
  always_comb begin
    if (funct3[2]) begin
      a_signed_in = ~funct3[0];
      b_signed_in = ~funct3[0];
    end else begin
      a_signed_in = (funct3[1:0] != 2'b11);
      b_signed_in = ~funct3[1];
    end
    a_neg_in = a_signed_in & rs1_data[31];
    b_neg_in = b_signed_in & rs2_data[31];
    a_mag_in = a_neg_in ? (~rs1_data + 32'd1) : rs1_data;
    b_mag_in = b_neg_in ? (~rs2_data + 32'd1) : rs2_data;
    // remainder follows the dividend sign; product and quotient follow the xor
    neg_in   = (funct3[2] & funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);

    div_zero_in = funct3[2] & (rs2_data == 32'd0);
    ovf_in      = funct3[2] & ~funct3[0] & (rs1_data == 32'h8000_0000) &
                  (rs2_data == 32'hFFFF_FFFF);
    special_in  = div_zero_in | ovf_in;
    special_val_in = 32'd0;
    if (div_zero_in)
      special_val_in = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
    else if (ovf_in)
      special_val_in = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One iteration step for either op class, plus the final result that is
  // registered on the last step.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift = {hi_q, lo_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_fits  = ~div_diff[32];
    if (op_q[2]) begin
      hi_nxt = div_fits ? div_diff[31:0] : div_shift[31:0];
      lo_nxt = {lo_q[30:0], div_fits};
    end else begin
      hi_nxt = mul_sum[32:1];
      lo_nxt = {mul_sum[0], lo_q[31:1]};
    end

    prod_s  = neg_q ? (~{hi_nxt, lo_nxt} + 64'd1) : {hi_nxt, lo_nxt};
    mul_res = (op_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
    div_raw = op_q[1] ? hi_nxt : lo_nxt;
    div_res = neg_q ? (~div_raw + 32'd1) : div_raw;

    if (special_q)
      final_res = special_val_q;
    else if (op_q[2])
      final_res = div_res;
    else
      final_res = mul_res;
  end

  // Sequencer: accept, iterate with a down-counter, publish result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= 32'd0;
      cnt_q         <= 5'd0;
      op_q          <= 3'd0;
      neg_q         <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= 32'd0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      opnd_q        <= 32'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            op_q          <= funct3;
            neg_q         <= neg_in;
            special_q     <= special_in;
            special_val_q <= special_val_in;
            cnt_q         <= 5'd31;
            hi_q          <= 32'd0;
            lo_q          <= funct3[2] ? a_mag_in : b_mag_in;
            opnd_q        <= funct3[2] ? b_mag_in : a_mag_in;
            if (special_in && (EARLY_OUT != 0)) begin
              state_q <= DONE;
              done    <= 1'b1;
              result  <= special_val_in;
            end else begin
              state_q <= CALC;
              busy    <= 1'b1;
            end
          end
        end
        CALC: begin
          hi_q <= hi_nxt;
          lo_q <= lo_nxt;
          if (cnt_q == 5'd0) begin
            state_q <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= final_res;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of single operations plus
// hand-written sequences for ignored start, back-to-back issue and reset abort.
module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  muldiv_unit #(.EARLY_OUT(1)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Present a request at the negedge; return #1 after the accepting edge
  // (cycle 1), with the operand inputs scrambled.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start    = 1'b1;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    @(posedge clock);
    #1;
    start    = 1'b0;
    funct3   = 3'($urandom_range(0, 7));
    rs1_data = $urandom;
    rs2_data = $urandom;
  endtask

  // Starting in cycle first_cyc, step until done; lat is the cycle index of
  // done (-1 on timeout), busy_ok says busy was 1 before and 0 at done.
  task automatic wait_done(input int first_cyc, output int lat,
                           output logic [31:0] res, output logic busy_ok);
    lat     = -1;
    res     = 32'hDEAD_BEEF;
    busy_ok = 1'b1;
    for (int k = first_cyc; k <= 60; k++) begin
      if (done) begin
        lat = k;
        res = result;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    logic        bok;
    int          seen;

    vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[7]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[8]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[9]  = '{3'b111, 32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1};
    vecs[11] = '{3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1};
    vecs[12] = '{3'b000, 32'h1234_5678, 32'd0,         32'h0000_0000, 33};
    vecs[13] = '{3'b011, 32'h8000_0000, 32'd2,         32'h0000_0001, 33};
    vecs[14] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[15] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[16] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[17] = '{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
    vecs[18] = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
    vecs[19] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[20] = '{3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33};
    vecs[21] = '{3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[22] = '{3'b110, 32'h8000_0000, 32'd3,         32'hFFFF_FFFE, 33};

    reset    = 1'b0;
    start    = 1'b0;
    funct3   = 3'd0;
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    #3;
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);
    check("reset_result", result,        32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b);
      wait_done(1, lat, res, bok);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy", i), {31'd0, bok}, 32'd1);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
      check($sformatf("vec%0d_result_hold", i), result, vecs[i].exp);
      @(posedge clock);
    end

    // start pulsed during CALC with different operands must be ignored
    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    start    = 1'b1;
    funct3   = 3'b101;
    rs1_data = 32'd100;
    rs2_data = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(2, lat, res, bok);
    check("ignore_result",  res,      32'hFFFF_FFEB);
    check("ignore_latency", 32'(lat), 32'd33);
    check("ignore_busy",    {31'd0, bok}, 32'd1);

    // back-to-back: issue in the DONE cycle
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("b2b_accepted_busy", {31'd0, busy}, 32'd1);
    check("b2b_prev_hold",     result,        32'hFFFF_FFEB);
    wait_done(1, lat, res, bok);
    check("b2b_result",  res,      32'hFFFF_FFFE);
    check("b2b_latency", 32'(lat), 32'd33);
    check("b2b_busy",    {31'd0, bok}, 32'd1);

    // reset in cycle 10 of a DIVU
    @(posedge clock);
    issue(3'b101, 32'd100, 32'd7);
    repeat (9) @(posedge clock);
    #1;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy",   {31'd0, busy}, 32'd0);
    check("abort_done",   {31'd0, done}, 32'd0);
    check("abort_result", result,        32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (done) seen++;
      if (k == 2) reset = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    issue(3'b111, 32'd100, 32'd7);
    wait_done(1, lat, res, bok);
    check("post_reset_result",  res,      32'd2);
    check("post_reset_latency", 32'(lat), 32'd33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
